imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory. Receives a program as a byte stream
//  (valid/ready), packs bytes into 32-bit little-endian words, and writes them sequentially
//  into instruction RAM from word 0. Pads unused words with NOP. Holds the core (busy) while loading.
// PARAMETERS
//  DEPTH      400           instruction memory depth in 32-bit words
//  NOP_WORD   32'h80000000  fill value for unwritten words (same NOP the fetch side returns out of range)
//  FILL_NOP   1             1: pad words count..DEPTH-1 with NOP_WORD; 0: skip padding
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse: begin new load (ignored while busy)
//  s_valid    in   1   stream byte valid
//  s_data     in   8   stream byte
//  s_ready    out  1   loader can accept byte; transfer = s_valid & s_ready
//  mem_we     out  1   write strobe to instruction RAM, 1-cycle pulses
//  mem_addr   out  32  word address (0..DEPTH-1)
//  mem_wdata  out  32  word to write
//  busy       out  1   load in progress; core must stall / stay in reset
//  done       out  1   load completed OK; held until next start
//  error      out  1   bad header; held until next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-load aborts; words already written stay in RAM.
//  States: IDLE, HDR0, HDR1, DATA, FILL, DONE, ERR. All outputs registered.
//  IDLE/DONE/ERR + start -> HDR0; done and error clear in that cycle.
//  HDR0: accept byte -> count[7:0]. HDR1: accept byte -> count[15:8].
//   After HDR1: count==0 or count>DEPTH -> ERR (error=1), else DATA.
//  DATA: byte_idx 0..3, byte k -> word[8k+7:8k] (little-endian).
//   On the 4th byte: next cycle mem_we=1, mem_addr=word_idx, mem_wdata=packed word; word_idx++.
//   Last word (word_idx==count-1): go to FILL if FILL_NOP && count<DEPTH, else DONE.
//  FILL: one write per cycle, mem_addr=fill_addr (starts at count), wdata=NOP_WORD.
//   First fill write is the cycle after the last data write; after writing DEPTH-1 -> DONE.
//  s_ready=1 only in HDR0, HDR1, DATA; otherwise 0. Bytes offered outside these states are not consumed.
//  busy=1 in HDR0, HDR1, DATA, FILL. done=1 only in DONE. error=1 only in ERR.
//  Bubbles: s_valid may drop anywhere mid-word; byte_idx holds, no write issued.
//  Max 1 byte/cycle, so data writes are >=4 cycles apart; no write collision.
//  start while busy: ignored, load continues unaffected.
//  mem_addr width 32 to match the fetch-side PC bus; upper bits are always 0.
// STRUCTURE
//  imem_pkg: IMEM_DEPTH=400, NOP_WORD=32'h80000000, typedef enum loader_state_t.
//  Sub-module byte_packer: 8->32 assembler (byte_idx, shift register, word_valid pulse).
//  imem_loader holds the FSM, header/count regs, word/fill address counters, output regs.
// TESTING
//  1 Reset, start, header 02 00, bytes 13 00 50 00 93 00 A0 00 -> writes addr0=00500013,
//    addr1=00A00093, then NOP at addr 2..399 (398 writes); done=1, busy=0.
//  2 Header 00 00 -> error=1 two cycles after 2nd header byte, no mem_we ever; start clears error.
//  3 Header 91 01 (401 > DEPTH) -> error=1, s_ready=0, no writes.
//  4 count=1 with s_valid toggling every other cycle, plus start pulses mid-load -> one write,
//    addr0 correct, starts ignored, busy stays 1 until fill ends.
//  5 count=400, FILL_NOP=1 -> 400 data writes, no FILL writes; done after addr 399.
//  6 Assert rst after 6 payload bytes -> all outputs 0 within the same cycle, one word written;
//    a new start reloads correctly from HDR0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default depth, NOP fill word, FSM states.
package imem_pkg;
    localparam int          IMEM_DEPTH    = 400;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_FILL,
        S_DONE,
        S_ERR
    } loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx <= 2'd0;
        end else if (i_clr) begin
            r_byte_idx <= 2'd0;
        end else if (i_valid) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    // Bytes enter at the top so the first byte ends up in bits [7:0] after three shifts.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_word_valid = i_valid && (r_byte_idx == 2'd3);
    assign o_word       = {i_byte, r_shift};
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM word by word, then pads with NOPs.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD,
    parameter bit          FILL_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t r_state;
    loader_state_t w_next;
    logic [15:0]   r_count;
    logic [15:0]   r_widx;
    logic [15:0]   w_hdr_count;
    logic          w_xfer;
    logic          w_start;
    logic          w_pack_vld;
    logic          w_word_valid;
    logic [31:0]   w_word;
    logic          w_last_word;
    logic          w_fill_last;

    assign w_xfer      = s_valid && s_ready;
    assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_pack_vld  = w_xfer && (r_state == S_DATA);
    assign w_hdr_count = {s_data, r_count[7:0]};
    assign w_last_word = (r_widx == r_count - 16'd1);
    assign w_fill_last = (r_widx == DEPTH16 - 16'd1);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start),
        .i_valid      (w_pack_vld),
        .i_byte       (s_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR0;
            S_HDR0: if (w_xfer) w_next = S_HDR1;
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_hdr_count == 16'd0 || w_hdr_count > DEPTH16) w_next = S_ERR;
                    else                                                w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_valid && w_last_word) begin
                    if (FILL_NOP && r_count < DEPTH16) w_next = S_FILL;
                    else                               w_next = S_DONE;
                end
            end
            S_FILL: if (w_fill_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    // One address counter serves both phases: after the last data word it already equals count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 16'd0;
            r_widx    <= 16'd0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            s_ready <= (w_next == S_HDR0) || (w_next == S_HDR1) || (w_next == S_DATA);
            busy    <= (w_next == S_HDR0) || (w_next == S_HDR1) || (w_next == S_DATA)
                    || (w_next == S_FILL);
            done    <= (w_next == S_DONE);
            error   <= (w_next == S_ERR);
            mem_we  <= 1'b0;

            if (w_start) begin
                r_widx <= 16'd0;
            end
            if (r_state == S_HDR0 && w_xfer) begin
                r_count[7:0] <= s_data;
            end
            if (r_state == S_HDR1 && w_xfer) begin
                r_count[15:8] <= s_data;
            end
            if (r_state == S_DATA && w_word_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= {16'd0, r_widx};
                mem_wdata <= w_word;
                r_widx    <= r_widx + 16'd1;
            end
            if (r_state == S_FILL) begin
                mem_we    <= 1'b1;
                mem_addr  <= {16'd0, r_widx};
                mem_wdata <= NOP_WORD;
                r_widx    <= r_widx + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected RAM writes come from a word-level model of the load.
module tb_imem_loader;
    localparam int          DEPTH = 400;
    localparam logic [31:0] NOP   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end

    // Reference: word w is payload bytes 4w..4w+3 little-endian, then NOP up to DEPTH-1.
    function automatic void model_load(input int cnt, input logic [7:0] pay[$]);
        exp_q.delete();
        for (int w = 0; w < cnt; w++) begin
            exp_q.push_back({32'(w), pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
        end
        for (int a = cnt; a < DEPTH; a++) begin
            exp_q.push_back({32'(a), NOP});
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubble);
        if (bubble) repeat ($urandom_range(2)) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        for (int n = 0; n < 20 && !s_ready; n++) @(negedge clk);
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_ready got %0b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout busy=%0b required 0", tag, busy);
        end
        @(negedge clk);
    endtask

    task automatic rand_payload(input int cnt, output logic [7:0] pay[$]);
        pay.delete();
        for (int i = 0; i < 4*cnt; i++) pay.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== 69'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, busy, done, error});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%0b s_ready=%0b required 0 0", busy, s_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pay[$];
        pay = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        model_load(2, pay);
        wr_q.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy busy=%0b s_ready=%0b required 1 1", busy, s_ready);
        end
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        foreach (pay[i]) send_byte(pay[i], 1'b0);
        wait_idle("basic");
        checks++;
        if (wr_q.size() != 400) begin
            errors++;
            $display("FAIL basic_wcount got %0d required 400", wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_write[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                break;
            end
        end
        checks++;
        if (wr_q.size() < 2 || wr_q[0][31:0] !== 32'h0050_0013 || wr_q[1][31:0] !== 32'h00A0_0093) begin
            errors++;
            $display("FAIL basic_words got %h required 00500013/00a00093", wr_q.size() > 0 ? wr_q[0] : 64'd0);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_status done=%0b busy=%0b error=%0b required 1 0 0", done, busy, error);
        end
    endtask

    task automatic test_zero_count();
        wr_q.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_clear got %0b required 0", done);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int n = 0; n < 3 && !error; n++) @(negedge clk);
        checks++;
        if (error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_error error=%0b s_ready=%0b busy=%0b required 1 0 0", error, s_ready, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_writes got %0d required 0", wr_q.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_restart error=%0b busy=%0b required 0 1", error, busy);
        end
    endtask

    task automatic test_bad_header();
        wr_q.delete();
        send_byte(8'h91, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int n = 0; n < 3 && !error; n++) @(negedge clk);
        s_valid = 1'b1;
        s_data = 8'h5A;
        repeat (4) @(negedge clk);
        checks++;
        if (error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL big_error error=%0b s_ready=%0b busy=%0b required 1 0 0", error, s_ready, busy);
        end
        s_valid = 1'b0;
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL big_writes got %0d required 0", wr_q.size());
        end
    endtask

    task automatic test_bubbles_start();
        logic [7:0] pay[$];
        int busy_low = 0;
        rand_payload(1, pay);
        model_load(1, pay);
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(pay[i], 1'b0);
            if (i < 3) begin
                start = (i != 0);
                @(negedge clk);
                start = 1'b0;
                if (!busy) busy_low++;
            end
        end
        while (busy === 1'b1 && wr_q.size() < 398) @(negedge clk);
        if (!busy) busy_low++;
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL bubble_busy low_samples got %0d required 0", busy_low);
        end
        wait_idle("bubble");
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bubble_wcount got %0d required %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bubble_write[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                break;
            end
        end
    endtask

    task automatic test_random_programs();
        logic [7:0] pay[$];
        int cnt;
        for (int it = 0; it < 3; it++) begin
            cnt = $urandom_range(12, 1);
            rand_payload(cnt, pay);
            model_load(cnt, pay);
            wr_q.delete();
            pulse_start();
            send_byte(8'(cnt), 1'b1);
            send_byte(8'h00, 1'b1);
            foreach (pay[i]) send_byte(pay[i], 1'b1);
            wait_idle("random");
            checks++;
            if (wr_q.size() != exp_q.size() || done !== 1'b1) begin
                errors++;
                $display("FAIL random%0d_wcount got %0d done=%0b required %0d 1", it, wr_q.size(), done, exp_q.size());
            end
            for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_write[%0d] got %h required %h", it, i, wr_q[i], exp_q[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] pay[$];
        rand_payload(DEPTH, pay);
        model_load(DEPTH, pay);
        wr_q.delete();
        pulse_start();
        send_byte(8'h90, 1'b0);
        send_byte(8'h01, 1'b0);
        foreach (pay[i]) send_byte(pay[i], 1'b0);
        wait_idle("full");
        checks++;
        if (wr_q.size() != DEPTH || done !== 1'b1) begin
            errors++;
            $display("FAIL full_wcount got %0d done=%0b required %0d 1", wr_q.size(), done, DEPTH);
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                break;
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] pay[$];
        rand_payload(3, pay);
        model_load(3, pay);
        wr_q.delete();
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pay[i], 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== 69'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h required 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, busy, done, error});
        end
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midreset_writes got %0d entries first %h required 1 entry %h",
                     wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 64'd0, exp_q[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_payload(5, pay);
        model_load(5, pay);
        wr_q.delete();
        pulse_start();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        foreach (pay[i]) send_byte(pay[i], 1'b1);
        wait_idle("reload");
        checks++;
        if (wr_q.size() != exp_q.size() || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_wcount got %0d done=%0b required %0d 1", wr_q.size(), done, exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reload_write[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                break;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_count();
        test_bad_header();
        test_bubbles_start();
        test_random_programs();
        test_full();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
